// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU-side SRAM-like bus arbiter.
package cpu_bus_pkg;

  // Arbitration modes
  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  // Transfer size encodings
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Channel index assignments
  localparam int unsigned CH_INST = 0;
  localparam int unsigned CH_DATA = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

  // Width of a channel id, never less than one bit
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_order_fifo.sv
// Order FIFO holding the issuing channel id of each outstanding transaction.
module bus_order_fifo
  import cpu_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ID_W  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [ID_W-1:0] push_id,
  input  logic            pop,
  output logic            full,
  output logic            empty,
  output logic [ID_W-1:0] head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ID_W-1:0] mem [DEPTH];
  logic [PTR_W:0]  wr_ptr;
  logic [PTR_W:0]  rd_ptr;
  logic            do_push;
  logic            do_pop;

  // Extra pointer bit distinguishes full from empty when indices match
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head    = mem[rd_ptr[PTR_W-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
    end
  end

  // Storage write; contents are qualified by the pointers so no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_id;
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// N-channel SRAM-like arbiter onto one shared slave port with in-order response routing.
module sram_like_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned N_CH     = 2,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ARB_MODE = 0
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [N_CH-1:0]          m_req,
  input  logic [N_CH-1:0]          m_wr,
  input  logic [2*N_CH-1:0]        m_size,
  input  logic [DATA_W/8*N_CH-1:0] m_wstrb,
  input  logic [ADDR_W*N_CH-1:0]   m_addr,
  input  logic [DATA_W*N_CH-1:0]   m_wdata,
  output logic [N_CH-1:0]          m_addr_ok,
  output logic [N_CH-1:0]          m_data_ok,
  output logic [DATA_W-1:0]        m_rdata,
  output logic                     s_req,
  output logic                     s_wr,
  output logic [1:0]               s_size,
  output logic [DATA_W/8-1:0]      s_wstrb,
  output logic [ADDR_W-1:0]        s_addr,
  output logic [DATA_W-1:0]        s_wdata,
  input  logic                     s_addr_ok,
  input  logic                     s_data_ok,
  input  logic [DATA_W-1:0]        s_rdata,
  output logic                     err
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned ID_W   = id_width(N_CH);

  logic [1:0]      rst_sync;
  logic            rst_n;
  arb_state_e      state;
  logic [ID_W-1:0] hold_id;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] sel_id;
  logic [ID_W-1:0] next_ptr;
  logic [ID_W-1:0] head;
  logic            any_req;
  logic            full;
  logic            empty;
  logic            hs;
  logic            pop;

  // Async-assert, sync-release reset for all internal state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // Winner selection: highest index in fixed mode, first from pointer in round-robin
  always_comb begin
    int unsigned idx;
    logic        found;
    win_id = '0;
    idx    = 0;
    found  = 1'b0;
    if (ARB_MODE == ARB_RR) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= N_CH) idx = idx - N_CH;
        if (!found && m_req[ID_W'(idx)]) begin
          found  = 1'b1;
          win_id = ID_W'(idx);
        end
      end
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (m_req[ID_W'(i)]) win_id = ID_W'(i);
      end
    end
  end

  assign any_req  = |m_req;
  assign sel_id   = (state == ST_HOLD) ? hold_id : win_id;
  assign s_req    = rst_n && ((state == ST_HOLD) || (any_req && !full));
  assign hs       = s_req && s_addr_ok;
  assign pop      = s_data_ok && !empty;
  assign next_ptr = (sel_id == ID_W'(N_CH - 1)) ? '0 : sel_id + ID_W'(1);

  // Slave request fields muxed from the selected channel, zero when idle
  always_comb begin
    s_wr    = 1'b0;
    s_size  = '0;
    s_wstrb = '0;
    s_addr  = '0;
    s_wdata = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (s_req && (sel_id == ID_W'(i))) begin
        s_wr    = m_wr[ID_W'(i)];
        s_size  = m_size[2*i +: 2];
        s_wstrb = m_wstrb[STRB_W*i +: STRB_W];
        s_addr  = m_addr[ADDR_W*i +: ADDR_W];
        s_wdata = m_wdata[DATA_W*i +: DATA_W];
      end
    end
  end

  assign m_addr_ok = hs  ? (N_CH'(1) << sel_id) : '0;
  assign m_data_ok = pop ? (N_CH'(1) << head)   : '0;
  assign m_rdata   = empty ? '0 : s_rdata;

  // Grant FSM, round-robin pointer and sticky protocol error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      hold_id <= '0;
      rr_ptr  <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_req && !s_addr_ok) begin
            state   <= ST_HOLD;
            hold_id <= win_id;
          end
        end
        ST_HOLD: begin
          if (s_addr_ok) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (hs) rr_ptr <= next_ptr;
      if ((s_data_ok && empty) || ((state == ST_HOLD) && !m_req[hold_id])) err <= 1'b1;
    end
  end

  bus_order_fifo #(
    .DEPTH (DEPTH),
    .ID_W  (ID_W)
  ) u_order_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (hs),
    .push_id (sel_id),
    .pop     (pop),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: one fixed-priority and one round-robin instance on shared stimulus.
module tb_sram_like_arbiter;
  import cpu_bus_pkg::*;

  localparam logic [31:0] A0 = 32'h1c00_0000;
  localparam logic [31:0] A1 = 32'h2000_0010;

  logic        clk;
  logic        resetn;
  logic [1:0]  m_req;
  logic [1:0]  m_wr;
  logic [3:0]  m_size;
  logic [7:0]  m_wstrb;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic        s_addr_ok;
  logic        s_data_ok;
  logic [31:0] s_rdata;

  logic [1:0]  f_m_addr_ok, f_m_data_ok, r_m_addr_ok, r_m_data_ok;
  logic [31:0] f_m_rdata, r_m_rdata;
  logic        f_s_req, f_s_wr, f_err, r_s_req, r_s_wr, r_err;
  logic [1:0]  f_s_size, r_s_size;
  logic [3:0]  f_s_wstrb, r_s_wstrb;
  logic [31:0] f_s_addr, f_s_wdata, r_s_addr, r_s_wdata;

  int errors = 0;
  int checks = 0;

  logic [1:0] rr_grant_exp [3];
  logic [1:0] drain_exp [3];

  sram_like_arbiter #(.N_CH(2), .ADDR_W(32), .DATA_W(32), .DEPTH(4), .ARB_MODE(ARB_FIXED)) u_fixed (
    .clk(clk), .resetn(resetn),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(f_m_addr_ok), .m_data_ok(f_m_data_ok), .m_rdata(f_m_rdata),
    .s_req(f_s_req), .s_wr(f_s_wr), .s_size(f_s_size), .s_wstrb(f_s_wstrb), .s_addr(f_s_addr), .s_wdata(f_s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata), .err(f_err)
  );

  sram_like_arbiter #(.N_CH(2), .ADDR_W(32), .DATA_W(32), .DEPTH(4), .ARB_MODE(ARB_RR)) u_rr (
    .clk(clk), .resetn(resetn),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(r_m_addr_ok), .m_data_ok(r_m_data_ok), .m_rdata(r_m_rdata),
    .s_req(r_s_req), .s_wr(r_s_wr), .s_size(r_s_size), .s_wstrb(r_s_wstrb), .s_addr(r_s_addr), .s_wdata(r_s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata), .err(r_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    m_req     = 2'b00;
    s_addr_ok = 1'b0;
    s_data_ok = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    tick();
    tick();
  endtask

  initial begin
    rr_grant_exp = '{2'b10, 2'b01, 2'b10};
    drain_exp    = '{2'b01, 2'b10, 2'b01};
    resetn    = 1'b0;
    m_req     = 2'b11;
    m_wr      = 2'b10;
    m_size    = {SZ_HALF, SZ_WORD};
    m_wstrb   = {4'h3, 4'hf};
    m_addr    = {A1, A0};
    m_wdata   = {32'h1111_2222, 32'h3333_4444};
    s_addr_ok = 1'b0;
    s_data_ok = 1'b0;
    s_rdata   = 32'hdead_beef;

    // Reset held with both channels requesting
    tick();
    tick();
    settle();
    chk("rst_s_req",     32'(f_s_req),     32'd0);
    chk("rst_s_addr",    f_s_addr,         32'd0);
    chk("rst_addr_ok",   32'(f_m_addr_ok), 32'd0);
    chk("rst_data_ok",   32'(f_m_data_ok), 32'd0);
    chk("rst_rdata",     f_m_rdata,        32'd0);
    chk("rst_err",       32'(f_err),       32'd0);

    // Release: ch1 wins in fixed mode
    resetn = 1'b1;
    tick();
    tick();
    settle();
    chk("rel_s_req",     32'(f_s_req),     32'd1);
    chk("rel_s_addr",    f_s_addr,         A1);
    chk("rel_addr_ok",   32'(f_m_addr_ok), 32'd0);
    s_addr_ok = 1'b1;
    settle();
    chk("fix_first_aok", 32'(f_m_addr_ok), 32'b10);
    chk("fix_wstrb",     32'(f_s_wstrb),   32'h3);
    chk("fix_size",      32'(f_s_size),    32'(SZ_HALF));
    chk("fix_wr",        32'(f_s_wr),      32'd1);
    tick();

    // Fixed priority: ch1 served every cycle, its responses routed back
    s_data_ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_rdata = 32'h1000 + 32'(k);
      settle();
      chk("fix_aok_ch1", 32'(f_m_addr_ok), 32'b10);
      chk("fix_dok_ch1", 32'(f_m_data_ok), 32'b10);
      chk("fix_rdata",   f_m_rdata,        32'h1000 + 32'(k));
      tick();
    end
    m_req = 2'b01;
    settle();
    chk("fix_aok_ch0",  32'(f_m_addr_ok), 32'b01);
    chk("fix_addr_ch0", f_s_addr,         A0);
    chk("fix_dok_last", 32'(f_m_data_ok), 32'b10);
    tick();
    m_req     = 2'b00;
    s_addr_ok = 1'b0;
    settle();
    chk("fix_dok_ch0",  32'(f_m_data_ok), 32'b01);
    chk("fix_sreq_off", 32'(f_s_req),     32'd0);
    chk("fix_err",      32'(f_err),       32'd0);
    tick();
    s_data_ok = 1'b0;

    // Round-robin: ch0 alone, then alternating grants 1,0,1 and FIFO fills
    do_reset();
    m_req     = 2'b01;
    s_addr_ok = 1'b1;
    settle();
    chk("rr_first_ch0", 32'(r_m_addr_ok), 32'b01);
    tick();
    m_req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("rr_grant", 32'(r_m_addr_ok), 32'(rr_grant_exp[k]));
      tick();
    end
    settle();
    chk("rr_full_sreq", 32'(r_s_req),     32'd0);
    chk("rr_full_aok",  32'(r_m_addr_ok), 32'd0);
    tick();
    s_data_ok = 1'b1;
    settle();
    chk("rr_pop_sreq",  32'(r_s_req),     32'd0);
    chk("rr_pop_dok",   32'(r_m_data_ok), 32'b01);
    tick();
    settle();
    chk("rr_refill_aok", 32'(r_m_addr_ok), 32'b01);
    chk("rr_refill_dok", 32'(r_m_data_ok), 32'b10);
    tick();
    m_req     = 2'b00;
    s_addr_ok = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("rr_drain_dok", 32'(r_m_data_ok), 32'(drain_exp[k]));
      tick();
    end
    s_data_ok = 1'b0;
    settle();
    chk("rr_err", 32'(r_err), 32'd0);

    // HOLD stability: ch0 held while ch1 arrives and slave stalls three cycles
    do_reset();
    m_req = 2'b01;
    settle();
    chk("hold_sreq",  32'(f_s_req), 32'd1);
    chk("hold_addr0", f_s_addr,     A0);
    tick();
    m_req = 2'b11;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("hold_addr",  f_s_addr,         A0);
      chk("hold_size",  32'(f_s_size),    32'(SZ_WORD));
      chk("hold_aok",   32'(f_m_addr_ok), 32'd0);
      tick();
    end
    s_addr_ok = 1'b1;
    settle();
    chk("hold_accept",      32'(f_m_addr_ok), 32'b01);
    chk("hold_accept_addr", f_s_addr,         A0);
    tick();
    s_addr_ok = 1'b0;
    settle();
    chk("hold_next_ch1", f_s_addr, A1);
    tick();

    // Master drops request while held: grant kept, error flagged
    m_req = 2'b01;
    settle();
    chk("drop_addr_held", f_s_addr, A1);
    chk("drop_err_pre",   32'(f_err), 32'd0);
    tick();
    settle();
    chk("drop_err", 32'(f_err), 32'd1);
    s_addr_ok = 1'b1;
    settle();
    chk("drop_aok_ch1", 32'(f_m_addr_ok), 32'b10);
    tick();

    // Response with nothing outstanding
    do_reset();
    s_rdata   = 32'hcafe_f00d;
    s_data_ok = 1'b1;
    settle();
    chk("spur_dok",   32'(f_m_data_ok), 32'd0);
    chk("spur_rdata", f_m_rdata,        32'd0);
    tick();
    s_data_ok = 1'b0;
    settle();
    chk("spur_err", 32'(f_err), 32'd1);
    tick();
    tick();
    settle();
    chk("spur_err_sticky", 32'(f_err), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
